// File: rtl/board_ctl.sv
// Battleship-style board controller: clears the grid, places ship cells and scores shots
// from mouse clicks. Define BOARD_CTL_SYNC_EN to add a 2-flop synchronizer on mouse_left.
module board_ctl #(
  parameter int X_POS      = 100,
  parameter int Y_POS      = 200,
  parameter int CELL_SIZE  = 32,
  parameter int GRID       = 12,
  parameter int SHIP_CELLS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] mouse_x_pos,
  input  logic [11:0] mouse_y_pos,
  input  logic        mouse_left,
  input  logic        start,
  output logic [7:0]  rd_addr,
  input  logic [1:0]  rd_data,
  output logic [7:0]  wr_addr,
  output logic [1:0]  wr_data,
  output logic        wr_enable,
  output logic [2:0]  state,
  output logic [4:0]  placed,
  output logic [4:0]  hits,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    PLACE  = 3'd2,
    ARMED  = 3'd3,
    LOOKUP = 3'd4,
    UPDATE = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam int          SHIFT      = $clog2(CELL_SIZE);
  localparam logic [12:0] X_LO       = 13'(X_POS);
  localparam logic [12:0] X_HI       = 13'(X_POS + GRID * CELL_SIZE);
  localparam logic [12:0] Y_LO       = 13'(Y_POS);
  localparam logic [12:0] Y_HI       = 13'(Y_POS + GRID * CELL_SIZE);
  localparam logic [3:0]  LAST       = 4'(GRID - 1);
  localparam logic [4:0]  SHIPS      = 5'(SHIP_CELLS);
  localparam logic [1:0]  CELL_EMPTY = 2'd0;
  localparam logic [1:0]  CELL_SHIP  = 2'd1;
  localparam logic [1:0]  CELL_MISS  = 2'd2;
  localparam logic [1:0]  CELL_HIT   = 2'd3;

  state_t      state_r;
  logic        firing_r;
  logic [3:0]  clr_row_r;
  logic [3:0]  clr_col_r;
  logic        ml_prev_r;
  logic        ml_s;
  logic        click_s;
  logic [12:0] x_ext_s;
  logic [12:0] y_ext_s;
  logic [12:0] dx_s;
  logic [12:0] dy_s;
  logic        in_grid_s;
  logic [7:0]  cell_s;
  logic [4:0]  placed_inc_s;
  logic [4:0]  hits_inc_s;

`ifdef BOARD_CTL_SYNC_EN
  logic ml_meta_r;
  logic ml_sync_r;

  // two-flop synchronizer ahead of edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ml_meta_r <= 1'b0;
      ml_sync_r <= 1'b0;
    end else begin
      ml_meta_r <= mouse_left;
      ml_sync_r <= ml_meta_r;
    end
  end

  assign ml_s = ml_sync_r;
`else
  assign ml_s = mouse_left;
`endif

  // previous button level for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ml_prev_r <= 1'b0;
    end else begin
      ml_prev_r <= ml_s;
    end
  end

  assign click_s      = ml_s & ~ml_prev_r;
  assign x_ext_s      = {1'b0, mouse_x_pos};
  assign y_ext_s      = {1'b0, mouse_y_pos};
  assign dx_s         = x_ext_s - X_LO;
  assign dy_s         = y_ext_s - Y_LO;
  assign in_grid_s    = (x_ext_s >= X_LO) && (x_ext_s < X_HI) &&
                        (y_ext_s >= Y_LO) && (y_ext_s < Y_HI);
  assign cell_s       = {4'(dy_s >> SHIFT), 4'(dx_s >> SHIFT)};
  // counters hold at SHIP_CELLS rather than wrapping
  assign placed_inc_s = (placed == SHIPS) ? placed : placed + 5'd1;
  assign hits_inc_s   = (hits == SHIPS) ? hits : hits + 5'd1;
  assign state        = state_r;

  // game FSM with registered memory strobes and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      firing_r  <= 1'b0;
      clr_row_r <= 4'd0;
      clr_col_r <= 4'd0;
      rd_addr   <= 8'd0;
      wr_addr   <= 8'd0;
      wr_data   <= 2'd0;
      wr_enable <= 1'b0;
      placed    <= 5'd0;
      hits      <= 5'd0;
      done      <= 1'b0;
    end else begin
      wr_enable <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r   <= CLEAR;
            placed    <= 5'd0;
            hits      <= 5'd0;
            done      <= 1'b0;
            clr_row_r <= 4'd0;
            clr_col_r <= 4'd0;
          end
        end
        CLEAR: begin
          wr_enable <= 1'b1;
          wr_addr   <= {clr_row_r, clr_col_r};
          wr_data   <= CELL_EMPTY;
          if (clr_col_r == LAST) begin
            clr_col_r <= 4'd0;
            if (clr_row_r == LAST) begin
              state_r <= PLACE;
            end else begin
              clr_row_r <= clr_row_r + 4'd1;
            end
          end else begin
            clr_col_r <= clr_col_r + 4'd1;
          end
        end
        PLACE, ARMED: begin
          if (click_s && in_grid_s) begin
            rd_addr  <= cell_s;
            firing_r <= (state_r == ARMED);
            state_r  <= LOOKUP;
          end
        end
        LOOKUP: begin
          state_r <= UPDATE;
        end
        UPDATE: begin
          if (!firing_r) begin
            if (rd_data == CELL_EMPTY) begin
              wr_enable <= 1'b1;
              wr_addr   <= rd_addr;
              wr_data   <= CELL_SHIP;
              placed    <= placed_inc_s;
              state_r   <= (placed_inc_s == SHIPS) ? ARMED : PLACE;
            end else begin
              state_r <= (placed == SHIPS) ? ARMED : PLACE;
            end
          end else begin
            case (rd_data)
              CELL_EMPTY: begin
                wr_enable <= 1'b1;
                wr_addr   <= rd_addr;
                wr_data   <= CELL_MISS;
                state_r   <= ARMED;
              end
              CELL_SHIP: begin
                wr_enable <= 1'b1;
                wr_addr   <= rd_addr;
                wr_data   <= CELL_HIT;
                hits      <= hits_inc_s;
                if (hits_inc_s == SHIPS) begin
                  state_r <= DONE;
                  done    <= 1'b1;
                end else begin
                  state_r <= ARMED;
                end
              end
              default: begin
                state_r <= ARMED;
              end
            endcase
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
